// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one registered writeback port between the fast execute path and the slow mul/div path.
// Optional WB_X0_FILTER_EN: rd==0 results complete their handshake but are never presented on the port.
module wb_port_arbiter #(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fast_valid,
    output logic                  fast_ready,
    input  logic [REG_ADDR_W-1:0] fast_rd,
    input  logic [DATA_W-1:0]     fast_data,
    input  logic                  slow_valid,
    output logic                  slow_ready,
    input  logic [REG_ADDR_W-1:0] slow_rd,
    input  logic [DATA_W-1:0]     slow_data,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  wb_src,
    output logic [3:0]            starve_cnt
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [DATA_W-1:0]     r_wb_data;
    logic                  r_wb_src;
    logic [3:0]            r_starve_cnt;

    logic                  w_load;
    logic                  w_force_slow;
    logic                  w_fast_xfer;
    logic                  w_slow_xfer;
    logic                  w_keep;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0]     w_data;

    // At most one of the two readys can be high while both valids are high.
    always_comb begin
        w_load       = !r_wb_valid || wb_ready;
        w_force_slow = r_starve_cnt == LIMIT;
        fast_ready   = !reset && w_load && !(w_force_slow && slow_valid);
        slow_ready   = !reset && w_load && (!fast_valid || w_force_slow);
        w_fast_xfer  = fast_valid && fast_ready;
        w_slow_xfer  = slow_valid && slow_ready;
        w_rd         = w_slow_xfer ? slow_rd : fast_rd;
        w_data       = w_slow_xfer ? slow_data : fast_data;
`ifdef WB_X0_FILTER_EN
        w_keep       = (w_fast_xfer || w_slow_xfer) && (w_rd != '0);
`else
        w_keep       = w_fast_xfer || w_slow_xfer;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wb_valid   <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
            r_wb_src     <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            if (w_load) r_wb_valid <= w_keep;
            if (w_load && w_keep) begin
                r_wb_rd   <= w_rd;
                r_wb_data <= w_data;
                r_wb_src  <= w_slow_xfer;
            end
            if (w_slow_xfer) r_starve_cnt <= '0;
            else if (slow_valid && w_load && r_starve_cnt < LIMIT) r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    assign wb_valid   = r_wb_valid;
    assign wb_rd      = r_wb_rd;
    assign wb_data    = r_wb_data;
    assign wb_src     = r_wb_src;
    assign starve_cnt = r_starve_cnt;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vector table, throughput run and randomized run against a transaction-level model.
module tb_wb_port_arbiter;
    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset, fast_valid, slow_valid, wb_ready;
    logic        fast_ready, slow_ready, wb_valid, wb_src;
    logic [4:0]  fast_rd, slow_rd, wb_rd;
    logic [31:0] fast_data, slow_data, wb_data;
    logic [3:0]  starve_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(32), .REG_ADDR_W(5), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .fast_valid(fast_valid), .fast_ready(fast_ready), .fast_rd(fast_rd), .fast_data(fast_data),
        .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_rd(slow_rd), .slow_data(slow_data),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_src(wb_src), .starve_cnt(starve_cnt)
    );

    typedef struct {
        logic        rst, fv;
        logic [4:0]  frd;
        logic [31:0] fd;
        logic        sv;
        logic [4:0]  srd;
        logic [31:0] sd;
        logic        wr, efr, esr, ev;
        logic [4:0]  erd;
        logic [31:0] ed;
        logic        esrc;
        logic [3:0]  ecnt;
    } vec_t;

`ifdef WB_X0_FILTER_EN
    localparam logic        X0V = 1'b0;
    localparam logic [4:0]  X0_RD = 5'd15;
    localparam logic [31:0] X0_D = 32'hA5;
    localparam bit          FILT = 1'b1;
`else
    localparam logic        X0V = 1'b1;
    localparam logic [4:0]  X0_RD = 5'd0;
    localparam logic [31:0] X0_D = 32'h1;
    localparam bit          FILT = 1'b0;
`endif

    function automatic vec_t mk(input logic rst, fv, input logic [4:0] frd, input logic [31:0] fd,
                                input logic sv, input logic [4:0] srd, input logic [31:0] sd,
                                input logic wr, efr, esr, ev, input logic [4:0] erd,
                                input logic [31:0] ed, input logic esrc, input logic [3:0] ecnt);
        vec_t v;
        v.rst = rst; v.fv = fv; v.frd = frd; v.fd = fd; v.sv = sv; v.srd = srd; v.sd = sd;
        v.wr = wr; v.efr = efr; v.esr = esr; v.ev = ev; v.erd = erd; v.ed = ed;
        v.esrc = esrc; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, fv, input logic [4:0] frd, input logic [31:0] fd,
                         input logic sv, input logic [4:0] srd, input logic [31:0] sd, input logic wr);
        reset = rst; fast_valid = fv; fast_rd = frd; fast_data = fd;
        slow_valid = sv; slow_rd = srd; slow_data = sd; wb_ready = wr;
    endtask

    vec_t tv[19];

    // Transaction-level reference state for the randomized run.
    bit          m_v, m_src, hold_f, hold_s, load, force_s, efr, esr;
    logic [4:0]  m_rd;
    logic [31:0] m_d;
    int          m_cnt, win;

    initial begin
        tv[0]  = mk(1,1,3,32'h12345000,0,0,0,1, 0,0, 0,0,0,0,0);
        tv[1]  = mk(1,1,3,32'h12345000,0,0,0,1, 0,0, 0,0,0,0,0);
        tv[2]  = mk(0,1,3,32'h12345000,0,0,0,1, 1,0, 1,3,32'h12345000,0,0);
        tv[3]  = mk(0,0,0,0,1,7,32'hDEADBEEF,1, 1,1, 1,7,32'hDEADBEEF,1,0);
        tv[4]  = mk(0,1,10,32'hA0,1,9,32'h99,1, 1,0, 1,10,32'hA0,0,1);
        tv[5]  = mk(0,1,11,32'hA1,1,9,32'h99,1, 1,0, 1,11,32'hA1,0,2);
        tv[6]  = mk(0,1,12,32'hA2,1,9,32'h99,1, 1,0, 1,12,32'hA2,0,3);
        tv[7]  = mk(0,1,13,32'hA3,1,9,32'h99,1, 1,0, 1,13,32'hA3,0,4);
        tv[8]  = mk(0,1,14,32'hA4,1,9,32'h99,1, 0,1, 1,9,32'h99,1,0);
        tv[9]  = mk(0,1,14,32'hA4,1,9,32'h99,1, 1,0, 1,14,32'hA4,0,1);
        tv[10] = mk(0,1,15,32'hA5,1,9,32'h99,0, 0,0, 1,14,32'hA4,0,1);
        tv[11] = mk(0,1,15,32'hA5,1,9,32'h99,0, 0,0, 1,14,32'hA4,0,1);
        tv[12] = mk(0,1,15,32'hA5,1,9,32'h99,0, 0,0, 1,14,32'hA4,0,1);
        tv[13] = mk(0,1,15,32'hA5,1,9,32'h99,1, 1,0, 1,15,32'hA5,0,2);
        tv[14] = mk(0,0,0,0,0,0,0,1, 1,1, 0,15,32'hA5,0,2);
        tv[15] = mk(0,1,0,32'h1,0,0,0,1, 1,0, X0V,X0_RD,X0_D,0,2);
        tv[16] = mk(0,0,0,0,0,0,0,1, 1,1, 0,X0_RD,X0_D,0,2);
        tv[17] = mk(0,1,5,32'h55,0,0,0,0, 1,0, 1,5,32'h55,0,2);
        tv[18] = mk(1,1,6,32'h66,0,0,0,0, 0,0, 0,0,0,0,0);

        for (int i = 0; i < 19; i++) begin
            drive(tv[i].rst, tv[i].fv, tv[i].frd, tv[i].fd, tv[i].sv, tv[i].srd, tv[i].sd, tv[i].wr);
            #1;
            chk($sformatf("vec%0d fast_ready", i), 64'(fast_ready), 64'(tv[i].efr));
            chk($sformatf("vec%0d slow_ready", i), 64'(slow_ready), 64'(tv[i].esr));
            @(posedge clk); #1;
            chk($sformatf("vec%0d wb_valid", i), 64'(wb_valid), 64'(tv[i].ev));
            chk($sformatf("vec%0d wb_rd", i), 64'(wb_rd), 64'(tv[i].erd));
            chk($sformatf("vec%0d wb_data", i), 64'(wb_data), 64'(tv[i].ed));
            chk($sformatf("vec%0d wb_src", i), 64'(wb_src), 64'(tv[i].esrc));
            chk($sformatf("vec%0d starve_cnt", i), 64'(starve_cnt), 64'(tv[i].ecnt));
        end

        for (int i = 1; i <= 8; i++) begin
            drive(0, 1, 5'(i), 32'(i * 256), 0, 0, 0, 1);
            #1;
            chk($sformatf("thru%0d fast_ready", i), 64'(fast_ready), 64'd1);
            @(posedge clk); #1;
            chk($sformatf("thru%0d wb_valid", i), 64'(wb_valid), 64'd1);
            chk($sformatf("thru%0d wb_rd", i), 64'(wb_rd), 64'(i));
        end

        drive(1, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        m_v = 0; m_rd = 0; m_d = 0; m_src = 0; m_cnt = 0;
        hold_f = 0; hold_s = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold_f) begin
                fast_valid = $urandom_range(0, 3) != 0;
                fast_rd = 5'($urandom);
                fast_data = $urandom;
            end
            if (!hold_s) begin
                slow_valid = $urandom_range(0, 1) != 0;
                slow_rd = 5'($urandom);
                slow_data = $urandom;
            end
            wb_ready = $urandom_range(0, 3) != 0;
            reset = $urandom_range(0, 99) == 0;
            #1;
            load = !m_v || wb_ready;
            force_s = m_cnt == LIM;
            win = (reset || !load) ? 0 : (slow_valid && (force_s || !fast_valid)) ? 2 : fast_valid ? 1 : 0;
            efr = !reset && load && !(force_s && slow_valid);
            esr = !reset && load && (!fast_valid || force_s);
            chk("rnd fast_ready", 64'(fast_ready), 64'(efr));
            chk("rnd slow_ready", 64'(slow_ready), 64'(esr));
            hold_f = fast_valid && !(win == 1);
            hold_s = slow_valid && !(win == 2);
            if (reset) begin
                m_v = 0; m_rd = 0; m_d = 0; m_src = 0; m_cnt = 0;
            end else begin
                if (load) begin
                    if (win != 0 && !(FILT && (win == 2 ? slow_rd : fast_rd) == 0)) begin
                        m_v = 1;
                        m_rd = win == 2 ? slow_rd : fast_rd;
                        m_d = win == 2 ? slow_data : fast_data;
                        m_src = win == 2;
                    end else m_v = 0;
                end
                if (win == 2) m_cnt = 0;
                else if (slow_valid && load && m_cnt < LIM) m_cnt++;
            end
            @(posedge clk); #1;
            chk("rnd wb_valid", 64'(wb_valid), 64'(m_v));
            chk("rnd wb_rd", 64'(wb_rd), 64'(m_rd));
            chk("rnd wb_data", 64'(wb_data), 64'(m_d));
            chk("rnd wb_src", 64'(wb_src), 64'(m_src));
            chk("rnd starve_cnt", 64'(starve_cnt), 64'(m_cnt));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file writeback port between two result producers.
- Fast path: the single-cycle execute result (ALU / U-type LUI, AUIPC), one result per cycle.
- Slow path: the multi-cycle mul/div unit.
- Fixed priority to the fast path, with a starvation counter that forces a slow-path grant. The output is a registered valid/ready stage feeding writeback.

Parameters:
- DATA_W, 32, result data width
- REG_ADDR_W, 5, destination register index width
- STARVE_LIMIT, 4, consecutive slow-path arbitration losses before the slow path is forced; legal range 1..15

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- fast_valid  input  1  fast-path result available
- fast_ready  output  1  fast-path result accepted this cycle
- fast_rd  input  REG_ADDR_W  fast-path destination register
- fast_data  input  DATA_W  fast-path result
- slow_valid  input  1  slow-path result available
- slow_ready  output  1  slow-path result accepted this cycle
- slow_rd  input  REG_ADDR_W  slow-path destination register
- slow_data  input  DATA_W  slow-path result
- wb_valid  output  1  writeback register holds a result
- wb_ready  input  1  writeback consumer accepts the result
- wb_rd  output  REG_ADDR_W  registered destination register
- wb_data  output  DATA_W  registered result
- wb_src  output  1  source of the held result: 0 = fast, 1 = slow
- starve_cnt  output  4  current starvation count (debug/observability)

Behaviour:
- Clock and reset: single clock domain (clk). reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: wb_valid=0, wb_rd=0, wb_data=0, wb_src=0, starve_cnt=0.
  - Reset asserted mid-transfer discards the held result; no handshake completes in a reset cycle.
  - fast_ready and slow_ready are 0 while reset is high.
- load = !wb_valid || wb_ready. This is the output register free/draining condition, combinational.
- force_slow = (starve_cnt == STARVE_LIMIT).
- Ready equations:
  - fast_ready = load && !(force_slow && slow_valid)
  - slow_ready = load && (!fast_valid || force_slow)
- fast_ready and slow_ready are never both asserted when both valids are high. Readys depend on valids only through these equations. Producers must hold valid/rd/data stable until their handshake completes.
- A transfer happens on a source when valid && ready. On the next edge:
  - wb_valid=1
  - wb_rd and wb_data are loaded from the winning source
  - wb_src is set to the winning source
  - Latency is exactly 1 cycle.
- load with no transfer: wb_valid goes to 0 on the next edge. wb_rd and wb_data hold their old values.
- wb_valid && !wb_ready: the output register holds. Both readys are 0 and no grant occurs.
- Starvation counter:
  - Increment (saturating at STARVE_LIMIT) when slow_valid && load && !slow_ready, i.e. the slow path lost to the fast path.
  - Clear to 0 on any slow transfer.
  - Unchanged while the output is stalled (!load) or while slow_valid=0.
- Back-to-back operation: with wb_ready held at 1, one result per cycle. No bubble between grants.
- Simultaneous events:
  - Both valid and counter below limit: fast wins.
  - Counter at limit: slow wins and the counter clears.
  - The fast path retries next cycle with its values held.

Optional Feature:
- Macro: WB_X0_FILTER_EN
- Defined:
  - A transfer with rd==0 completes the handshake normally (ready asserted as above) and updates the starvation counter as a normal grant.
  - It does not set wb_valid: the output register loads as if no transfer occurred. Writes to x0 never reach the port.
- Undefined: rd==0 results pass through unchanged with wb_rd=0. The register file is responsible for ignoring them.

Test Plan:
- Reset check: assert reset for 2 cycles while fast_valid=1 (rd=3, data=0x12345000) -> wb_valid=0, fast_ready=0, starve_cnt=0. After reset release, wb_valid=1, wb_rd=3, wb_data=0x12345000 one cycle later.
- Single-source latency: slow_valid=1 (rd=7, data=0xDEADBEEF), fast idle, wb_ready=1 -> slow_ready=1 that cycle. Next cycle wb_valid=1, wb_rd=7, wb_src=1, starve_cnt=0.
- Starvation with STARVE_LIMIT=4: fast_valid held 1, slow_valid held 1, wb_ready=1 -> four fast grants (starve_cnt 1,2,3,4), then fifth cycle slow_ready=1 and fast_ready=0. Then starve_cnt=0 and fast resumes winning.
- Output stall: fill the output, drop wb_ready for 3 cycles with both valids high -> both readys 0, wb_rd/wb_data/wb_src stable, starve_cnt unchanged. On wb_ready=1 the next grant occurs in the same cycle.
- Throughput: fast_valid=1 for 8 cycles with distinct rd=1..8, wb_ready=1 -> wb sequence rd=1..8 on 8 consecutive cycles, no gaps.
- X0 filter (WB_X0_FILTER_EN defined): fast transfer with rd=0, data=0x1 -> fast_ready=1, wb_valid stays 0. With the macro undefined -> wb_valid=1, wb_rd=0.
